// File: rtl/beacon_framer.sv
// beacon_framer: periodic 9-byte telemetry beacon streamed over a valid/ready byte handshake.
module beacon_framer #(
    parameter logic [7:0] PERIOD_TICKS = 8'd10,
    parameter logic [7:0] SYNC0        = 8'hEB,
    parameter logic [7:0] SYNC1        = 8'h90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        tx_enable,
    input  logic [15:0] alt,
    input  logic [15:0] temp,
    input  logic [7:0]  status,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic [7:0]  seq
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t      state_q, state_d;
    logic [7:0]  tick_cnt_q, tick_cnt_d, seq_q, seq_d, status_q, status_d, csum, mux;
    logic [15:0] alt_q, alt_d, temp_q, temp_d;
    logic [3:0]  idx_q, idx_d;
    logic        frame_done_q, frame_done_d, overrun_q, overrun_d, req;
    always_comb begin
        req          = tx_enable && tick && tick_cnt_q == 8'd0;
        tick_cnt_d   = !tx_enable ? 8'd0 : !tick ? tick_cnt_q :
                       (tick_cnt_q == PERIOD_TICKS - 8'd1) ? 8'd0 : tick_cnt_q + 8'd1;
        state_d      = state_q;
        idx_d        = idx_q;
        seq_d        = seq_q;
        alt_d        = alt_q;
        temp_d       = temp_q;
        status_d     = status_q;
        frame_done_d = 1'b0;
        overrun_d    = req && state_q == SEND;
        if (state_q == IDLE) begin
            if (req) begin
                state_d  = SEND;
                idx_d    = 4'd0;
                alt_d    = alt;
                temp_d   = temp;
                status_d = status;
            end
        end else if (byte_ready) begin
            if (idx_q == 4'd8) begin
                state_d      = IDLE;
                seq_d        = seq_q + 8'd1;
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end
    // seq_q only advances when the frame ends, so it doubles as the frame's sequence snapshot
    always_comb begin
        csum = seq_q + alt_q[15:8] + alt_q[7:0] + temp_q[15:8] + temp_q[7:0] + status_q;
        case (idx_q)
            4'd0:    mux = SYNC0;
            4'd1:    mux = SYNC1;
            4'd2:    mux = seq_q;
            4'd3:    mux = alt_q[15:8];
            4'd4:    mux = alt_q[7:0];
            4'd5:    mux = temp_q[15:8];
            4'd6:    mux = temp_q[7:0];
            4'd7:    mux = status_q;
            default: mux = csum;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= 8'd0;
            seq_q        <= 8'd0;
            idx_q        <= 4'd0;
            alt_q        <= 16'd0;
            temp_q       <= 16'd0;
            status_q     <= 8'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            alt_q        <= alt_d;
            temp_q       <= temp_d;
            status_q     <= status_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end
    assign byte_valid = state_q == SEND;
    assign busy       = byte_valid;
    assign byte_data  = byte_valid ? mux : 8'd0;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign seq        = seq_q;
endmodule

// File: tb/tb_beacon_framer.sv
// tb_beacon_framer: randomized scenario tests of beacon_framer against a frame-level model.
module tb_beacon_framer;
    localparam int P = 10;
    logic        clk = 0, reset = 0, tick = 0, tx_enable = 0, byte_ready = 0;
    logic [15:0] alt = 0, temp = 0;
    logic [7:0]  status = 0;
    logic [7:0]  byte_data, seq;
    logic        byte_valid, busy, frame_done, overrun;
    int          tests = 0, fails = 0, fd_cnt = 0, ov_cnt = 0;
    logic [7:0]  rx[$];

    beacon_framer dut (
        .clk(clk), .reset(reset), .tick(tick), .tx_enable(tx_enable),
        .alt(alt), .temp(temp), .status(status), .byte_ready(byte_ready),
        .byte_data(byte_data), .byte_valid(byte_valid), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .seq(seq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (byte_valid && byte_ready) rx.push_back(byte_data);
        if (frame_done) fd_cnt++;
        if (overrun) ov_cnt++;
    end

    function automatic logic [71:0] model(logic [7:0] s, logic [15:0] a, logic [15:0] t, logic [7:0] st);
        int sum;
        sum = s + a[15:8] + a[7:0] + t[15:8] + t[7:0] + st;
        return {8'hEB, 8'h90, s, a, t, st, 8'(sum % 256)};
    endfunction

    function automatic logic [71:0] got(int base);
        logic [71:0] r = '0;
        for (int i = 0; i < 9; i++) r = {r[63:0], (base + i < rx.size()) ? rx[base + i] : 8'hXX};
        return r;
    endfunction

    task automatic cyc(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_tick(int gap);
        tick = 1; cyc(1); tick = 0; cyc(gap);
    endtask

    task automatic do_reset();
        reset = 0; tick = 0; tx_enable = 0; byte_ready = 0;
        cyc(2);
        rx.delete(); fd_cnt = 0; ov_cnt = 0;
        reset = 1;
        cyc(1);
    endtask

    task automatic randomize_inputs();
        alt = 16'($urandom); temp = 16'($urandom); status = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 0; cyc(1);
        tests++;
        if ({byte_data, byte_valid, busy, frame_done, overrun, seq} !== 20'd0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", {byte_data, byte_valid, busy, frame_done, overrun, seq});
        end
        do_reset();
        cyc(3);
        tests++;
        if (byte_valid !== 1'b0 || rx.size() != 0) begin
            fails++; $display("FAIL reset_idle: valid %b bytes %0d expected 0 0", byte_valid, rx.size());
        end
    endtask

    task automatic test_basic();
        logic [71:0] exp_f;
        do_reset();
        tx_enable = 1; byte_ready = 1; alt = 16'h1234; temp = 16'hABCD; status = 8'h5A;
        exp_f = model(8'h00, alt, temp, status);
        tick = 1; cyc(1); tick = 0;
        tests++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hEB) begin
            fails++; $display("FAIL basic_start: valid %b data %h expected 1 eb", byte_valid, byte_data);
        end
        cyc(8);
        tests++;
        if (byte_valid !== 1'b1 || byte_data !== exp_f[7:0]) begin
            fails++; $display("FAIL basic_csum_cycle: valid %b data %h expected 1 %h", byte_valid, byte_data, exp_f[7:0]);
        end
        cyc(1);
        tests++;
        if ({byte_valid, busy, frame_done} !== 3'b001) begin
            fails++; $display("FAIL basic_end: valid/busy/done %b expected 001", {byte_valid, busy, frame_done});
        end
        cyc(1);
        tests++;
        if (frame_done !== 1'b0) begin
            fails++; $display("FAIL basic_done_width: got %b expected 0", frame_done);
        end
        tests++;
        if (rx.size() != 9 || got(0) !== exp_f) begin
            fails++; $display("FAIL basic_frame: got %h (%0d bytes) expected %h", got(0), rx.size(), exp_f);
        end
        tests++;
        if (seq !== 8'd1) begin
            fails++; $display("FAIL basic_seq: got %0d expected 1", seq);
        end
    endtask

    task automatic test_period();
        logic [71:0] exp_q[$];
        logic [7:0] s = 0;
        do_reset();
        tx_enable = 1; byte_ready = 1;
        for (int k = 1; k <= 25; k++) begin
            randomize_inputs();
            if ((k - 1) % P == 0) begin exp_q.push_back(model(s, alt, temp, status)); s++; end
            pulse_tick(2);
        end
        cyc(12);
        tests++;
        if (rx.size() != 9 * exp_q.size()) begin
            fails++; $display("FAIL period_bytes: got %0d expected %0d", rx.size(), 9 * exp_q.size());
        end
        for (int f = 0; f < exp_q.size(); f++) begin
            tests++;
            if (got(9 * f) !== exp_q[f]) begin
                fails++; $display("FAIL period_frame%0d: got %h expected %h", f, got(9 * f), exp_q[f]);
            end
        end
        tests++;
        if (seq !== 8'd3 || ov_cnt != 0 || fd_cnt != 3) begin
            fails++; $display("FAIL period_status: seq %0d ov %0d done %0d expected 3 0 3", seq, ov_cnt, fd_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [71:0] exp_f;
        logic pv = 0, pr = 0;
        logic [7:0] pd = 0;
        int n = 0;
        do_reset();
        tx_enable = 1; alt = 16'h1234; randomize_inputs(); alt = 16'h1234;
        exp_f = model(8'h00, alt, temp, status);
        tick = 1; cyc(1); tick = 0;
        while (fd_cnt == 0 && n < 80) begin
            if (pv && !pr) begin
                tests++;
                if (byte_valid !== 1'b1 || byte_data !== pd) begin
                    fails++; $display("FAIL bp_hold: valid %b data %h expected 1 %h", byte_valid, byte_data, pd);
                end
            end
            byte_ready = (n % 4 == 0) || (n % 4 == 3);
            if (rx.size() >= 1) alt = 16'hFFFF;
            pv = byte_valid; pd = byte_data; pr = byte_ready; n++;
            cyc(1);
        end
        byte_ready = 0;
        tests++;
        if (n >= 80) begin
            fails++; $display("FAIL bp_timeout: cycles %0d expected < 80", n);
        end
        tests++;
        if (rx.size() != 9 || got(0) !== exp_f) begin
            fails++; $display("FAIL bp_frame: got %h (%0d bytes) expected %h", got(0), rx.size(), exp_f);
        end
    endtask

    task automatic test_overrun();
        logic [71:0] exp_f;
        do_reset();
        tx_enable = 1; randomize_inputs();
        exp_f = model(8'h00, alt, temp, status);
        for (int k = 1; k <= 11; k++) begin
            tick = 1; cyc(1); tick = 0;
            tests++;
            if (overrun !== (k == 11)) begin
                fails++; $display("FAIL ovr_pulse_tick%0d: got %b expected %b", k, overrun, k == 11);
            end
            cyc(1);
            if (k == 11) begin
                tests++;
                if (overrun !== 1'b0) begin
                    fails++; $display("FAIL ovr_width: got %b expected 0", overrun);
                end
            end
        end
        byte_ready = 1;
        cyc(12);
        tests++;
        if (rx.size() != 9 || got(0) !== exp_f || fd_cnt != 1 || ov_cnt != 1 || seq !== 8'd1) begin
            fails++; $display("FAIL ovr_result: frame %h bytes %0d done %0d ov %0d seq %0d expected %h 9 1 1 1",
                              got(0), rx.size(), fd_cnt, ov_cnt, seq, exp_f);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tx_enable = 1; byte_ready = 1; randomize_inputs();
        for (int k = 0; k < 255 * P; k++) pulse_tick(1);
        cyc(12);
        tests++;
        if (seq !== 8'd255) begin
            fails++; $display("FAIL wrap_preload: seq %0d expected 255", seq);
        end
        rx.delete();
        for (int k = 0; k < 2 * P; k++) pulse_tick(1);
        cyc(12);
        tests++;
        if (got(0) !== model(8'hFF, alt, temp, status) || got(9) !== model(8'h00, alt, temp, status)) begin
            fails++; $display("FAIL wrap_frames: got %h %h expected %h %h", got(0), got(9),
                              model(8'hFF, alt, temp, status), model(8'h00, alt, temp, status));
        end
        tests++;
        if (seq !== 8'd1) begin
            fails++; $display("FAIL wrap_seq: got %0d expected 1", seq);
        end
    endtask

    task automatic test_window();
        logic [71:0] exp_f;
        do_reset();
        tx_enable = 1; byte_ready = 1; randomize_inputs();
        exp_f = model(8'h00, alt, temp, status);
        tick = 1; cyc(1); tick = 0;
        cyc(4);
        tx_enable = 0;
        for (int k = 0; k < 15; k++) pulse_tick(1);
        tests++;
        if (rx.size() != 9 || got(0) !== exp_f || fd_cnt != 1 || ov_cnt != 0 || busy !== 1'b0) begin
            fails++; $display("FAIL win_close: frame %h bytes %0d done %0d ov %0d busy %b expected %h 9 1 0 0",
                              got(0), rx.size(), fd_cnt, ov_cnt, busy, exp_f);
        end
        tx_enable = 1; randomize_inputs();
        exp_f = model(8'h01, alt, temp, status);
        tick = 1; cyc(1); tick = 0;
        tests++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hEB) begin
            fails++; $display("FAIL win_reopen: valid %b data %h expected 1 eb", byte_valid, byte_data);
        end
        cyc(12);
        tests++;
        if (rx.size() != 18 || got(9) !== exp_f) begin
            fails++; $display("FAIL win_frame2: got %h (%0d bytes) expected %h", got(9), rx.size(), exp_f);
        end
    endtask

    task automatic test_reset_mid();
        logic [71:0] exp_f;
        do_reset();
        tx_enable = 1; byte_ready = 1; randomize_inputs();
        tick = 1; cyc(1); tick = 0;
        cyc(5);
        reset = 0; #1;
        tests++;
        if ({byte_valid, busy, byte_data} !== 10'd0) begin
            fails++; $display("FAIL rst_mid_async: valid %b busy %b data %h expected 0 0 00", byte_valid, busy, byte_data);
        end
        cyc(1);
        reset = 1; cyc(1);
        rx.delete();
        randomize_inputs();
        exp_f = model(8'h00, alt, temp, status);
        tick = 1; cyc(1); tick = 0;
        tests++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hEB) begin
            fails++; $display("FAIL rst_mid_restart: valid %b data %h expected 1 eb", byte_valid, byte_data);
        end
        cyc(12);
        tests++;
        if (rx.size() != 9 || got(0) !== exp_f || seq !== 8'd1) begin
            fails++; $display("FAIL rst_mid_frame: got %h (%0d bytes) seq %0d expected %h 9 1", got(0), rx.size(), seq, exp_f);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_period();
        test_backpressure();
        test_overrun();
        test_wrap();
        test_window();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
